// File: rtl/bspline_decim2.sv
// rtl/bspline_decim2.sv - 2:1 decimating 4-tap B-spline anti-alias filter (weights 3,61,61,3)
module bspline_decim2 #(
  parameter int DIN_W = 8,
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] din,
  output logic             dout_valid,
  output logic [DIN_W-1:0] dout
);

  localparam int PW = DIN_W + 6;
  localparam int SW = DIN_W + 7;
  localparam logic [SW-1:0] RND = (ROUND != 0) ? SW'(64) : '0;

  logic [DIN_W-1:0] x0_q, x1_q, x2_q, x3_q;
  logic [DIN_W-1:0] x0_d, x1_d, x2_d, x3_d;
  logic [2:0]       fill_q, fill_d;
  logic             phase_q, phase_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [PW-1:0]    p0_q, p1_q, p2_q, p3_q;
  logic [PW-1:0]    p0_d, p1_d, p2_d, p3_d;
  logic [DIN_W-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  logic             emit;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    rounded;

  // Next-state: history shift, decimation phase, two-stage multiply/add pipeline
  always_comb begin
    x0_d         = x0_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    x3_d         = x3_q;
    fill_d       = fill_q;
    phase_d      = phase_q;
    v1_d         = 1'b0;
    v2_d         = 1'b0;
    p0_d         = p0_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    p3_d         = p3_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    // Emit when the sample being accepted completes a full window on the odd phase
    emit    = din_valid && phase_q && (fill_q >= 3'd3);
    sum     = SW'(p0_q) + SW'(p1_q) + SW'(p2_q) + SW'(p3_q);
    rounded = sum + RND;

    if (clr) begin
      x0_d    = '0;
      x1_d    = '0;
      x2_d    = '0;
      x3_d    = '0;
      fill_d  = '0;
      phase_d = 1'b0;
      p0_d    = '0;
      p1_d    = '0;
      p2_d    = '0;
      p3_d    = '0;
      dout_d  = '0;
    end else begin
      if (din_valid) begin
        x0_d    = x1_q;
        x1_d    = x2_q;
        x2_d    = x3_q;
        x3_d    = din;
        fill_d  = (fill_q == 3'd4) ? 3'd4 : 3'(fill_q + 3'd1);
        phase_d = ~phase_q;
      end
      v1_d = emit;
      // Products taken from the window as it stood right after the emitting accept
      if (v1_q) begin
        p0_d = PW'(3)  * PW'(x0_q);
        p1_d = PW'(61) * PW'(x1_q);
        p2_d = PW'(61) * PW'(x2_q);
        p3_d = PW'(3)  * PW'(x3_q);
      end
      v2_d = v1_q;
      // Weights sum to 128, so the scaled result always fits in DIN_W bits
      if (v2_q) begin
        dout_d = DIN_W'(rounded >> 7);
      end
      dout_valid_d = v2_q;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q         <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      fill_q       <= '0;
      phase_q      <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      p0_q         <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      x3_q         <= x3_d;
      fill_q       <= fill_d;
      phase_q      <= phase_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      p3_q         <= p3_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_bspline_decim2.sv
// tb/tb_bspline_decim2.sv - scoreboard bench for bspline_decim2 (rounding and truncating builds)
module tb_bspline_decim2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'd0;
  logic       dv_r, dv_t;
  logic [7:0] dout_r, dout_t;

  bspline_decim2 #(.DIN_W(8), .ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .dout_valid(dv_r), .dout(dout_r)
  );

  bspline_decim2 #(.DIN_W(8), .ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .clr(clr), .din_valid(din_valid), .din(din),
    .dout_valid(dv_t), .dout(dout_t)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int vr;
    int vt;
  } exp_t;

  exp_t sb[$];
  int   samples[$];
  int   checks = 0;
  int   errors = 0;
  int   last_r = 0;
  int   last_t = 0;
  bit   done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Reference: every even-numbered accepted sample (4th onward) closes a window of the last four
  task automatic model_accept(input int d);
    int n, s;
    samples.push_back(d);
    n = samples.size();
    if (n >= 4 && (n % 2) == 0) begin
      s = 3 * samples[n-4] + 61 * samples[n-3] + 61 * samples[n-2] + 3 * samples[n-1];
      sb.push_back('{cyc + 3, (s + 64) / 128, s / 128});
    end
  endtask

  task automatic model_clear();
    samples.delete();
    sb.delete();
    last_r = 0;
    last_t = 0;
  endtask

  task automatic step(input bit v, input int d, input bit c = 1'b0);
    @(negedge clk);
    #1;
    din_valid = v;
    din       = d[7:0];
    clr       = c;
    if (c) model_clear();
    else if (v) model_accept(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst       = 1'b1;
    din_valid = 1'b0;
    clr       = 1'b0;
    model_clear();
    #1;
    check("rst_async_dout_round", dout_r, 0);
    check("rst_async_dout_trunc", dout_t, 0);
    check("rst_async_valid", dv_r, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pulse timing, result values, and hold-between-pulses
  initial begin
    bit   exp_pulse;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        exp_pulse = (sb.size() > 0) && (sb[0].due == cyc);
        check("valid_round", dv_r, exp_pulse);
        check("valid_trunc", dv_t, exp_pulse);
        if (exp_pulse) begin
          e = sb.pop_front();
          check("dout_round", dout_r, e.vr);
          check("dout_trunc", dout_t, e.vt);
          last_r = e.vr;
          last_t = e.vt;
        end else begin
          check("hold_round", dout_r, last_r);
          check("hold_trunc", dout_t, last_t);
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_dout", dout_r, 0);
    check("reset_valid", dv_r, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Constant input, back-to-back
    repeat (12) step(1'b1, 100);
    step(1'b0, 0);

    // Impulse response
    do_reset();
    step(1'b1, 0); step(1'b1, 0); step(1'b1, 0); step(1'b1, 128);
    repeat (6) step(1'b1, 0);
    repeat (3) step(1'b0, 0);

    // Full scale, then 254/255 alternation
    do_reset();
    repeat (8) step(1'b1, 255);
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2) ? 255 : 254);
    repeat (3) step(1'b0, 0);

    // Sparse input, one valid every three cycles
    do_reset();
    repeat (8) begin
      step(1'b1, 50);
      step(1'b0, 0);
      step(1'b0, 0);
    end
    repeat (3) step(1'b0, 0);

    // Clear with a simultaneous valid sample
    do_reset();
    repeat (5) step(1'b1, 40);
    step(1'b1, 99, 1'b1);
    repeat (5) step(1'b1, 60);
    repeat (3) step(1'b0, 0);

    // Reset right after an emitting accept
    do_reset();
    repeat (8) step(1'b1, 77);
    do_reset();
    repeat (6) step(1'b1, 100);
    repeat (3) step(1'b0, 0);

    // Randomised valid, data and occasional clear
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, int'($urandom_range(0, 255)), $urandom_range(0, 99) < 2);
    end
    repeat (6) step(1'b0, 0);

    check("scoreboard_drained", sb.size(), 0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
